xor_write_align_hazard: RTL



---
 rtl/xor_write_align_hazard.sv | 114 +++++++++++
 1 files changed

// File: rtl/xor_write_align_hazard.sv
// rtl/xor_write_align_hazard.sv - XOR multi-write table write stage with read-latency alignment and index hazard stall
module xor_write_align_hazard #(
    parameter int NUM_MUL     = 4,
    parameter int NUM_WR      = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int VALUE_WIDTH = 31,
    parameter int KEY_WIDTH   = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LAT      = 3
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     en_in,
    input  logic [1:0]                               opt_in,
    input  logic [INDEX_WIDTH-1:0]                   index_in,
    input  logic [KEY_WIDTH-1:0]                     key_in,
    input  logic [VALUE_WIDTH-1:0]                   value_in,
    output logic                                     in_ready,
    input  logic [NUM_MUL*(NUM_WR-1)*DATA_WIDTH-1:0] rd_BRAM_out_other,
    output logic [INDEX_WIDTH-1:0]                   rd_index,
    output logic                                     rd_valid,
    output logic [NUM_MUL*DATA_WIDTH-1:0]            write_reg_xor,
    output logic [INDEX_WIDTH-1:0]                   write_index,
    output logic                                     write_valid,
    output logic [31:0]                              stall_cnt
);

    localparam int DEPTH  = RD_LAT + 1;
    localparam int OTHERS = NUM_WR - 1;
    localparam int FLAG   = KEY_WIDTH + VALUE_WIDTH;

    logic [DEPTH-1:0]       live_q;
    logic [DEPTH-1:0]       wr_q;
    logic [INDEX_WIDTH-1:0] idx_q [DEPTH];
    logic [DATA_WIDTH-1:0]  rec_q [DEPTH];
    logic [31:0]            stall_q;
    logic [31:0]            stall_d;

    logic                   hit;
    logic                   accept;
    logic                   new_wr;
    logic [DATA_WIDTH-1:0]  new_rec;

    // The last stage is committing this cycle, so only S1..S(RD_LAT) can conflict.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (live_q[k] && wr_q[k] && (idx_q[k] == index_in)) begin
                hit = 1'b1;
            end
        end
        hit = hit & en_in;
    end

    assign in_ready = ~reset & ~hit;
    assign accept   = en_in & in_ready;
    assign new_wr   = (opt_in == 2'b01) || (opt_in == 2'b11);

    always_comb begin
        new_rec                          = '0;
        new_rec[FLAG]                    = ~opt_in[1];
        new_rec[FLAG-1:KEY_WIDTH]        = value_in;
        new_rec[KEY_WIDTH-1:0]           = key_in;
    end

    always_comb begin
        stall_d = stall_q;
        if (en_in && !in_ready) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Bubbles carry zero index/record so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q  <= '0;
            wr_q    <= '0;
            stall_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx_q[k] <= '0;
                rec_q[k] <= '0;
            end
        end else begin
            live_q   <= {live_q[DEPTH-2:0], accept};
            wr_q     <= {wr_q[DEPTH-2:0], accept & new_wr};
            idx_q[0] <= accept ? index_in : '0;
            rec_q[0] <= accept ? new_rec : '0;
            for (int k = 1; k < DEPTH; k++) begin
                idx_q[k] <= idx_q[k-1];
                rec_q[k] <= rec_q[k-1];
            end
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        write_reg_xor = '0;
        for (int i = 0; i < NUM_MUL; i++) begin
            write_reg_xor[i*DATA_WIDTH +: DATA_WIDTH] = rec_q[RD_LAT];
            for (int j = 0; j < OTHERS; j++) begin
                write_reg_xor[i*DATA_WIDTH +: DATA_WIDTH] =
                    write_reg_xor[i*DATA_WIDTH +: DATA_WIDTH] ^
                    rd_BRAM_out_other[(i*OTHERS + j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_index    = idx_q[0];
    assign rd_valid    = live_q[0];
    assign write_index = idx_q[RD_LAT];
    assign write_valid = live_q[RD_LAT] & wr_q[RD_LAT];
    assign stall_cnt   = stall_q;

endmodule
